// File: rtl/nexys_operand_entry_if.sv
// Operand-entry bus: raw board inputs in, committed adder operands and status out.
// The design side uses the slave modport; the driver of buttons and switches uses master.
interface nexys_operand_entry_if;
  logic        BTNC;
  logic        BTNU;
  logic        BTNL;
  logic        BTNR;
  logic        BTND;
  logic [15:0] SW;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic        carry_o;
  logic        valid_o;
  logic        hi_sel_o;
  logic        dirty_o;

  modport master (
    output BTNC, BTNU, BTNL, BTNR, BTND, SW,
    input  a_o, b_o, carry_o, valid_o, hi_sel_o, dirty_o
  );

  modport slave (
    input  BTNC, BTNU, BTNL, BTNR, BTND, SW,
    output a_o, b_o, carry_o, valid_o, hi_sel_o, dirty_o
  );
endinterface

// File: rtl/nexys_operand_entry.sv
// Operand entry for a 32-bit adder from five push-buttons and 16 switches.
// Buttons are synchronized and debounced; each debounced press is one event.
// Edits go to shadow registers; BTNC commits them to the adder-facing outputs.
// Button vector order (index 4..0): C, L, R, D, U -- also the event priority.
module nexys_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                  CLK100,
  input  logic                  resetn,
  nexys_operand_entry_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    EDIT   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [4:0]       w_rawBtn;
  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_level;
  logic [4:0]       r_levelD;
  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       w_press;
  logic [4:0]       w_masked;

  logic             w_evtC;
  logic             w_evtL;
  logic             w_evtR;
  logic             w_evtD;
  logic             w_evtU;
  logic             w_valid;

  logic [31:0]      r_shA;
  logic [31:0]      r_shB;
  logic             r_shC;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_carry;
  logic             r_hiSel;
  logic             r_dirty;

  assign w_rawBtn = {bus.BTNC, bus.BTNL, bus.BTNR, bus.BTND, bus.BTNU};

  // Two-flop synchronizer so nothing downstream sees the raw asynchronous buttons.
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_rawBtn;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      r_level  <= '0;
      r_levelD <= '0;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_levelD <= r_level;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= ~r_level[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of a debounced level is a press; a second BTNC during COMMIT is dropped.
  assign w_press  = r_level & ~r_levelD;
  assign w_masked = w_press & {(r_state != COMMIT), 4'b1111};

  // Keep only the highest-priority event of the cycle.
  always_comb begin
    w_evtC = 1'b0;
    w_evtL = 1'b0;
    w_evtR = 1'b0;
    w_evtD = 1'b0;
    w_evtU = 1'b0;
    if (w_masked[4])      w_evtC = 1'b1;
    else if (w_masked[3]) w_evtL = 1'b1;
    else if (w_masked[2]) w_evtR = 1'b1;
    else if (w_masked[1]) w_evtD = 1'b1;
    else if (w_masked[0]) w_evtU = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge CLK100) begin
    if (!resetn) r_state <= EDIT;
    else         r_state <= w_nextState;
  end

  // FSM next state; valid_o is high for the single COMMIT cycle.
  always_comb begin
    w_nextState = r_state;
    w_valid     = 1'b0;
    case (r_state)
      EDIT:    if (w_evtC) w_nextState = COMMIT;
      COMMIT: begin
        w_valid     = 1'b1;
        w_nextState = EDIT;
      end
      default: w_nextState = EDIT;
    endcase
  end

  // Shadow edits, half select and commit of shadows into the adder-facing registers.
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      r_shA   <= '0;
      r_shB   <= '0;
      r_shC   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_hiSel <= 1'b0;
      r_dirty <= 1'b0;
    end else if (w_evtC) begin
      r_a     <= r_shA;
      r_b     <= r_shB;
      r_carry <= r_shC;
      r_dirty <= 1'b0;
    end else if (w_evtL) begin
      if (r_hiSel) r_shA[31:16] <= bus.SW;
      else         r_shA[15:0]  <= bus.SW;
      r_dirty <= 1'b1;
    end else if (w_evtR) begin
      if (r_hiSel) r_shB[31:16] <= bus.SW;
      else         r_shB[15:0]  <= bus.SW;
      r_dirty <= 1'b1;
    end else if (w_evtD) begin
      r_shC   <= ~r_shC;
      r_dirty <= 1'b1;
    end else if (w_evtU) begin
      r_hiSel <= ~r_hiSel;
    end
  end

  assign bus.a_o      = r_a;
  assign bus.b_o      = r_b;
  assign bus.carry_o  = r_carry;
  assign bus.valid_o  = w_valid;
  assign bus.hi_sel_o = r_hiSel;
  assign bus.dirty_o  = r_dirty;

endmodule

// File: tb/tb_nexys_operand_entry.sv
// Directed bench for nexys_operand_entry with DEBOUNCE_CYCLES = 4,
// so a held button takes effect on the 7th clock edge after it rises.
module tb_nexys_operand_entry;

  localparam int DEB = 4;

  // Button vector order (index 4..0): C, L, R, D, U.
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_D = 5'b00010;
  localparam logic [4:0] B_U = 5'b00001;

  logic       clk100;
  logic       resetn;
  logic [4:0] btnVec;
  logic [15:0] swVal;

  int totalCount;
  int passCount;
  int validCount;
  int v0;

  nexys_operand_entry_if bus ();

  assign bus.BTNC = btnVec[4];
  assign bus.BTNL = btnVec[3];
  assign bus.BTNR = btnVec[2];
  assign bus.BTND = btnVec[1];
  assign bus.BTNU = btnVec[0];
  assign bus.SW   = swVal;

  nexys_operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLK100 (clk100),
    .resetn (resetn),
    .bus    (bus)
  );

  // 100 MHz clock.
  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  // Count valid_o pulses, sampled on the falling edge.
  always @(negedge clk100) begin
    if (bus.valid_o === 1'b1) validCount++;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Wait n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Hold a set of buttons, release, and let the release debounce out.
  task automatic applyStimulus(input logic [4:0] mask, input int hold);
    btnVec = mask;
    tick(hold);
    btnVec = '0;
    tick(10);
  endtask

  initial begin
    totalCount = 0;
    passCount  = 0;
    validCount = 0;
    btnVec     = '0;
    swVal      = '0;
    resetn     = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);

    // Reset state
    checkOutput("rst_a", bus.a_o, 32'h0);
    checkOutput("rst_b", bus.b_o, 32'h0);
    checkOutput("rst_carry", {31'b0, bus.carry_o}, 32'h0);
    checkOutput("rst_valid", {31'b0, bus.valid_o}, 32'h0);
    checkOutput("rst_hisel", {31'b0, bus.hi_sel_o}, 32'h0);
    checkOutput("rst_dirty", {31'b0, bus.dirty_o}, 32'h0);

    // Write low half of A, then commit with exact timing
    swVal = 16'h00AB;
    applyStimulus(B_L, 20);
    checkOutput("editA_dirty", {31'b0, bus.dirty_o}, 32'h1);
    checkOutput("editA_a_held", bus.a_o, 32'h0);
    v0 = validCount;
    btnVec = B_C;
    tick(6);
    checkOutput("commit1_early_valid", {31'b0, bus.valid_o}, 32'h0);
    checkOutput("commit1_early_a", bus.a_o, 32'h0);
    tick(1);
    checkOutput("commit1_valid", {31'b0, bus.valid_o}, 32'h1);
    checkOutput("commit1_a", bus.a_o, 32'h000000AB);
    tick(1);
    checkOutput("commit1_valid_off", {31'b0, bus.valid_o}, 32'h0);
    btnVec = '0;
    tick(10);
    checkOutput("commit1_pulses", validCount - v0, 32'd1);
    checkOutput("commit1_b", bus.b_o, 32'h0);
    checkOutput("commit1_carry", {31'b0, bus.carry_o}, 32'h0);
    checkOutput("commit1_dirty", {31'b0, bus.dirty_o}, 32'h0);

    // Upper half of B
    applyStimulus(B_U, 20);
    checkOutput("hisel_set", {31'b0, bus.hi_sel_o}, 32'h1);
    swVal = 16'h1234;
    applyStimulus(B_R, 20);
    applyStimulus(B_C, 20);
    checkOutput("commit2_b", bus.b_o, 32'h12340000);
    checkOutput("commit2_a", bus.a_o, 32'h000000AB);

    // Bouncing BTNL never settles; then steady high fires on the 7th edge
    swVal = 16'h5555;
    for (int k = 0; k < 7; k++) begin
      btnVec = B_L;
      tick(2);
      btnVec = '0;
      tick(2);
    end
    tick(4);
    checkOutput("bounce_dirty", {31'b0, bus.dirty_o}, 32'h0);
    btnVec = B_L;
    tick(6);
    checkOutput("steady_early_dirty", {31'b0, bus.dirty_o}, 32'h0);
    tick(1);
    checkOutput("steady_dirty", {31'b0, bus.dirty_o}, 32'h1);
    btnVec = '0;
    tick(10);
    applyStimulus(B_C, 20);
    checkOutput("commit3_a", bus.a_o, 32'h555500AB);

    // BTNC and BTND together: commit only
    v0 = validCount;
    applyStimulus(B_C | B_D, 20);
    checkOutput("cd_pulses", validCount - v0, 32'd1);
    checkOutput("cd_carry", {31'b0, bus.carry_o}, 32'h0);
    checkOutput("cd_dirty", {31'b0, bus.dirty_o}, 32'h0);
    applyStimulus(B_D, 20);
    checkOutput("d_dirty", {31'b0, bus.dirty_o}, 32'h1);
    applyStimulus(B_C, 20);
    checkOutput("commit4_carry", {31'b0, bus.carry_o}, 32'h1);

    // Commit with nothing edited
    v0 = validCount;
    applyStimulus(B_C, 20);
    checkOutput("clean_pulses", validCount - v0, 32'd1);
    checkOutput("clean_a", bus.a_o, 32'h555500AB);
    checkOutput("clean_b", bus.b_o, 32'h12340000);
    checkOutput("clean_carry", {31'b0, bus.carry_o}, 32'h1);

    // Edits then reset one cycle before the BTNC event lands
    applyStimulus(B_U, 20);
    swVal = 16'hFFFF;
    applyStimulus(B_L, 20);
    applyStimulus(B_D, 20);
    v0 = validCount;
    btnVec = B_C;
    tick(5);
    checkOutput("prereset_valid", {31'b0, bus.valid_o}, 32'h0);
    resetn = 1'b0;
    btnVec = '0;
    tick(1);
    resetn = 1'b1;
    tick(12);
    checkOutput("abort_pulses", validCount - v0, 32'd0);
    checkOutput("abort_a", bus.a_o, 32'h0);
    checkOutput("abort_b", bus.b_o, 32'h0);
    checkOutput("abort_carry", {31'b0, bus.carry_o}, 32'h0);
    checkOutput("abort_hisel", {31'b0, bus.hi_sel_o}, 32'h0);
    checkOutput("abort_dirty", {31'b0, bus.dirty_o}, 32'h0);

    // Button held through reset fires on the 7th edge after release
    btnVec = B_U;
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(6);
    checkOutput("held_early_hisel", {31'b0, bus.hi_sel_o}, 32'h0);
    tick(1);
    checkOutput("held_hisel", {31'b0, bus.hi_sel_o}, 32'h1);
    btnVec = '0;
    tick(10);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
